pmem_line_arbiter: RTL and testbench
====================================

// Module: pmem_line_arbiter
// PURPOSE
//  Shares the single cacheline_adaptor port between the I-cache (read-only) and D-cache
//  (read/write-back) miss paths. Round-robin arbitration on contention; full line transfers
//  granted atomically until pmem_resp_c. Sits between both caches and the adaptor in mp4.
// PARAMETERS
//  s_offset  5  log2 bytes per line; line width LW = 2**s_offset*8 (256 bits at default)
// PORTS
//  clk            in   1   clock, single domain
//  rst            in   1   asynchronous, active-high reset
//  i_pmem_read    in   1   I-cache line-read request (level, held until i_pmem_resp)
//  i_pmem_address in   32  I-cache line address
//  i_pmem_rdata   out  LW  line returned to I-cache
//  i_pmem_resp    out  1   one-cycle completion pulse to I-cache
//  d_pmem_read    in   1   D-cache line-read request (level)
//  d_pmem_write   in   1   D-cache write-back request (level)
//  d_pmem_address in   32  D-cache line address
//  d_pmem_wdata   in   LW  write-back line
//  d_pmem_rdata   out  LW  line returned to D-cache
//  d_pmem_resp    out  1   one-cycle completion pulse to D-cache
//  pmem_read_c    out  1   read to adaptor, held until pmem_resp_c
//  pmem_write_c   out  1   write to adaptor, held until pmem_resp_c
//  pmem_address_c out  32  line address to adaptor, low s_offset bits forced 0
//  pmem_wdata_c   out  LW  write line to adaptor
//  pmem_rdata_c   in   LW  line from adaptor
//  pmem_resp_c    in   1   adaptor completion pulse
// BEHAVIOUR
//  - States: IDLE, SERVE_I, SERVE_D (+PREFETCH, see CONFIGURATION). rst -> IDLE, all outputs 0,
//    last_grant=I (D wins first tie), latched address/op/wdata cleared.
//  - IDLE: sample requests; single requester granted; both -> the one NOT equal to last_grant.
//    On grant latch address, op, wdata; next cycle enter SERVE_x. Adaptor outputs are driven
//    only from latched copies, never from live request inputs.
//  - SERVE_x: pmem_read_c/pmem_write_c held from first SERVE cycle until pmem_resp_c. In the
//    pmem_resp_c cycle: x_pmem_resp=1 and x_pmem_rdata=pmem_rdata_c (combinational pass-through,
//    rdata also held in register afterwards); last_grant<=x; next state IDLE.
//  - Latency: request -> adaptor op start 1 cycle; adaptor resp -> cache resp 0 cycles.
//    Min 1 IDLE cycle between transactions so requesters can drop the request.
//  - Request dropped mid-service: ignored, transaction completes, resp still pulsed.
//  - d_pmem_read & d_pmem_write both high: write wins; simulation assertion fires.
//  - pmem_resp_c while IDLE: ignored, no resp pulse; assertion fires.
//  - rst asserted mid-transfer: immediate IDLE, adaptor read/write drop same cycle.
//  - Never both x_pmem_resp high; never pmem_read_c & pmem_write_c high together.
// CONFIGURATION
//  ARB_NEXT_LINE_PREFETCH_EN defined: one-line prefetch buffer (pf_valid, pf_addr, pf_line).
//  - After SERVE_I completes for address A, if IDLE sees no request, enter PREFETCH: read A+2**s_offset
//    (32-bit wrap) into buffer; on pmem_resp_c set pf_valid. No cache resp for PREFETCH.
//  - IDLE priority: D demand > I buffer hit > I demand > prefetch start.
//  - I request with pf_valid and line match: i_pmem_resp next cycle from pf_line, no adaptor
//    traffic, then prefetch next line. Counts as I grant for round-robin.
//  - Requests arriving during PREFETCH wait until it completes (adaptor not abortable).
//  - D write whose line equals pf_addr (IDLE grant or during PREFETCH) clears pf_valid on/after
//    completion. rst clears pf_valid.
//  Undefined: no buffer or PREFETCH state; I misses always go to adaptor.
// TESTING
//  - Reset: rst=1 with both requests high -> all outputs 0, state IDLE; release -> D granted first.
//  - Lone I read 0x0000_1040 -> pmem_address_c=0x0000_1040 next cycle, adaptor resp after 10
//    cycles -> i_pmem_resp 1 cycle, i_pmem_rdata=pmem_rdata_c, d_pmem_resp stays 0.
//  - I and D reads held together, 4 rounds -> grants D,I,D,I; adaptor address 0x0000_2007 input
//    -> pmem_address_c=0x0000_2000.
//  - D write 0x0000_3000 with wdata pattern 0xA5.. -> pmem_write_c=1, pmem_wdata_c matches,
//    pmem_read_c=0 throughout; rst mid-transfer -> write drops same cycle, IDLE.
//  - PREFETCH_EN: I miss 0x0000_1000 then idle -> adaptor read 0x0000_1020; I req 0x0000_1020
//    -> resp in 1 cycle, no adaptor read until prefetch of 0x0000_1040.
//  - PREFETCH_EN: prefetch 0x0000_1020 valid, D write 0x0000_1020 -> pf_valid=0, next I req
//    0x0000_1020 goes to adaptor.

Source files
------------

// File: rtl/pmem_line_arbiter.sv
// pmem_line_arbiter: round-robin sharing of one cacheline adaptor between I-cache and D-cache misses
// Optional next-line I prefetch buffer when ARB_NEXT_LINE_PREFETCH_EN is defined.
module pmem_line_arbiter #(
  parameter int s_offset = 5,
  localparam int LW = (2**s_offset)*8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_pmem_read,
  input  logic [31:0]   i_pmem_address,
  output logic [LW-1:0] i_pmem_rdata,
  output logic          i_pmem_resp,
  input  logic          d_pmem_read,
  input  logic          d_pmem_write,
  input  logic [31:0]   d_pmem_address,
  input  logic [LW-1:0] d_pmem_wdata,
  output logic [LW-1:0] d_pmem_rdata,
  output logic          d_pmem_resp,
  output logic          pmem_read_c,
  output logic          pmem_write_c,
  output logic [31:0]   pmem_address_c,
  output logic [LW-1:0] pmem_wdata_c,
  input  logic [LW-1:0] pmem_rdata_c,
  input  logic          pmem_resp_c
);
  localparam logic [31:0] LMASK = ~((32'd1 << s_offset) - 32'd1);
`ifdef ARB_NEXT_LINE_PREFETCH_EN
  localparam logic [31:0] LSTEP = 32'd1 << s_offset;
  typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, PREFETCH, PF_HIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
`endif
  state_t state_q, state_d;
  logic last_d_q, last_d_d, wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [LW-1:0] wdata_q, wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic want_i, want_d, pick_d, serve_i, serve_d, pf_out, pf_rd;
  logic [LW-1:0] pf_data;
  assign want_i = i_pmem_read;
  assign want_d = d_pmem_read | d_pmem_write;
  // last_d_q low means I was served last, so D takes the next tie
  assign pick_d = want_d & (~want_i | ~last_d_q);
  assign serve_i = (state_q == SERVE_I) & pmem_resp_c;
  assign serve_d = (state_q == SERVE_D) & pmem_resp_c;
`ifdef ARB_NEXT_LINE_PREFETCH_EN
  logic pf_valid_q, pf_valid_d, pf_pend_q, pf_pend_d, pf_hit;
  logic [31:0] pf_addr_q, pf_addr_d, last_i_q, last_i_d;
  logic [LW-1:0] pf_line_q, pf_line_d;
  assign pf_out = state_q == PF_HIT;
  assign pf_rd = state_q == PREFETCH;
  assign pf_data = pf_line_q;
  assign pf_hit = pf_valid_q & ((i_pmem_address & LMASK) == pf_addr_q);
`else
  assign pf_out = 1'b0;
  assign pf_rd = 1'b0;
  assign pf_data = '0;
`endif
  assign i_pmem_resp = serve_i | pf_out;
  assign i_pmem_rdata = serve_i ? pmem_rdata_c : pf_out ? pf_data : i_rdata_q;
  assign d_pmem_resp = serve_d;
  assign d_pmem_rdata = serve_d ? pmem_rdata_c : d_rdata_q;
  assign pmem_read_c = ((state_q == SERVE_I) | (state_q == SERVE_D) | pf_rd) & ~wr_q;
  assign pmem_write_c = (state_q == SERVE_D) & wr_q;
  assign pmem_address_c = addr_q;
  assign pmem_wdata_c = wdata_q;
  always_comb begin
    state_d = state_q;
    last_d_d = last_d_q;
    wr_d = wr_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
`ifdef ARB_NEXT_LINE_PREFETCH_EN
    pf_valid_d = pf_valid_q;
    pf_pend_d = pf_pend_q;
    pf_addr_d = pf_addr_q;
    pf_line_d = pf_line_q;
    last_i_d = last_i_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d = SERVE_D;
          addr_d = d_pmem_address & LMASK;
          wr_d = d_pmem_write;
          wdata_d = d_pmem_wdata;
`ifdef ARB_NEXT_LINE_PREFETCH_EN
          pf_pend_d = 1'b0;
          if (d_pmem_write && (d_pmem_address & LMASK) == pf_addr_q) pf_valid_d = 1'b0;
`endif
        end else if (want_i) begin
          state_d = SERVE_I;
          addr_d = i_pmem_address & LMASK;
          wr_d = 1'b0;
`ifdef ARB_NEXT_LINE_PREFETCH_EN
          pf_pend_d = 1'b0;
          if (pf_hit) state_d = PF_HIT;
        end else if (pf_pend_q) begin
          state_d = PREFETCH;
          addr_d = last_i_q + LSTEP;
          wr_d = 1'b0;
          pf_addr_d = last_i_q + LSTEP;
          pf_valid_d = 1'b0;
          pf_pend_d = 1'b0;
`endif
        end
      end
      SERVE_I: if (pmem_resp_c) begin
        state_d = IDLE;
        last_d_d = 1'b0;
        i_rdata_d = pmem_rdata_c;
`ifdef ARB_NEXT_LINE_PREFETCH_EN
        last_i_d = addr_q;
        pf_pend_d = 1'b1;
`endif
      end
      SERVE_D: if (pmem_resp_c) begin
        state_d = IDLE;
        last_d_d = 1'b1;
        d_rdata_d = pmem_rdata_c;
      end
`ifdef ARB_NEXT_LINE_PREFETCH_EN
      PREFETCH: if (pmem_resp_c) begin
        state_d = IDLE;
        pf_line_d = pmem_rdata_c;
        pf_valid_d = 1'b1;
      end
      PF_HIT: begin
        state_d = IDLE;
        last_d_d = 1'b0;
        i_rdata_d = pf_line_q;
        last_i_d = pf_addr_q;
        pf_pend_d = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_d_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_d_q <= last_d_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end
`ifdef ARB_NEXT_LINE_PREFETCH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pf_valid_q <= 1'b0;
      pf_pend_q <= 1'b0;
      pf_addr_q <= '0;
      pf_line_q <= '0;
      last_i_q <= '0;
    end else begin
      pf_valid_q <= pf_valid_d;
      pf_pend_q <= pf_pend_d;
      pf_addr_q <= pf_addr_d;
      pf_line_q <= pf_line_d;
      last_i_q <= last_i_d;
    end
  end
`endif
  a_d_rw_excl: assert property (@(posedge clk) disable iff (rst) !(d_pmem_read && d_pmem_write));
  a_no_idle_resp: assert property (@(posedge clk) disable iff (rst) !(state_q == IDLE && pmem_resp_c));
endmodule

// File: tb/tb_pmem_line_arbiter.sv
// tb_pmem_line_arbiter: transaction-level model plus directed vectors for pmem_line_arbiter
module tb_pmem_line_arbiter;
  localparam int SO = 5;
  localparam int LW = (2**SO)*8;
  localparam logic [31:0] LMASK = ~((32'd1 << SO) - 32'd1);
  logic clk = 1'b0, rst;
  logic i_pmem_read, d_pmem_read, d_pmem_write, i_pmem_resp, d_pmem_resp;
  logic pmem_read_c, pmem_write_c, pmem_resp_c;
  logic [31:0] i_pmem_address, d_pmem_address, pmem_address_c;
  logic [LW-1:0] i_pmem_rdata, d_pmem_rdata, d_pmem_wdata, pmem_wdata_c, pmem_rdata_c;
  int cmp_n = 0, err_n = 0;
  bit chk_en = 0;
  int dut_grants[$];
  int model_grants[$];

  pmem_line_arbiter #(.s_offset(SO)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read_c(pmem_read_c), .pmem_write_c(pmem_write_c),
    .pmem_address_c(pmem_address_c), .pmem_wdata_c(pmem_wdata_c),
    .pmem_rdata_c(pmem_rdata_c), .pmem_resp_c(pmem_resp_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Model: one outstanding line transaction at a time, owner chosen by round-robin
  bit m_act, m_own_d, m_wr, m_last_d;
  logic [31:0] m_addr;
  logic [LW-1:0] m_wdata, m_irdata, m_drdata;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 0; m_own_d = 0; m_wr = 0; m_last_d = 0;
      m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
    end else if (m_act) begin
      if (pmem_resp_c) begin
        if (m_own_d) m_drdata = pmem_rdata_c; else m_irdata = pmem_rdata_c;
        m_last_d = m_own_d;
        m_act = 0;
      end
    end else if (i_pmem_read || d_pmem_read || d_pmem_write) begin
      m_own_d = (d_pmem_read || d_pmem_write) && !(i_pmem_read && m_last_d);
      m_addr = (m_own_d ? d_pmem_address : i_pmem_address) & LMASK;
      m_wr = m_own_d && d_pmem_write;
      if (m_own_d) m_wdata = d_pmem_wdata;
      m_act = 1;
      model_grants.push_back(m_own_d ? 2 : 1);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      automatic bit exp_ir = m_act && !m_own_d && pmem_resp_c;
      automatic bit exp_dr = m_act && m_own_d && pmem_resp_c;
      chk("i_resp", LW'(i_pmem_resp), LW'(exp_ir));
      chk("d_resp", LW'(d_pmem_resp), LW'(exp_dr));
      chk("read_c", LW'(pmem_read_c), LW'(m_act && !m_wr));
      chk("write_c", LW'(pmem_write_c), LW'(m_act && m_wr));
      chk("i_rdata", i_pmem_rdata, exp_ir ? pmem_rdata_c : m_irdata);
      chk("d_rdata", d_pmem_rdata, exp_dr ? pmem_rdata_c : m_drdata);
      if (m_act) chk("addr_c", LW'(pmem_address_c), LW'(m_addr));
      if (m_act && m_wr) chk("wdata_c", pmem_wdata_c, m_wdata);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Adaptor: wait for an operation, hold it lat cycles, then pulse resp with data
  task automatic serve(input int lat, input logic [LW-1:0] data, output int who);
    int t = 0;
    who = 0;
    while (!(pmem_read_c || pmem_write_c) && t < 20) begin
      tick();
      t++;
    end
    if (t == 20) begin
      cmp_n++;
      err_n++;
      $display("FAIL adaptor_wait: got no op within %0d cycles want op", t);
      return;
    end
    repeat (lat) tick();
    pmem_rdata_c = data;
    pmem_resp_c = 1;
    #2;
    who = (i_pmem_resp ? 1 : 0) + (d_pmem_resp ? 2 : 0);
    tick();
    pmem_resp_c = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int who;
    logic [LW-1:0] pat;
    rst = 1;
    i_pmem_read = 1; i_pmem_address = 32'h0000_4000;
    d_pmem_read = 1; d_pmem_write = 0; d_pmem_address = 32'h0000_2007;
    d_pmem_wdata = '0; pmem_rdata_c = '0; pmem_resp_c = 0;
    repeat (3) tick();
    chk_en = 1;
    chk("rst_read_c", LW'(pmem_read_c), '0);
    chk("rst_write_c", LW'(pmem_write_c), '0);
    chk("rst_addr_c", LW'(pmem_address_c), '0);
    chk("rst_resps", LW'({i_pmem_resp, d_pmem_resp}), '0);
    chk("rst_rdata", i_pmem_rdata | d_pmem_rdata | pmem_wdata_c, '0);
    rst = 0;
    tick();
    chk("rr_first_addr", LW'(pmem_address_c), LW'(32'h0000_2000));
    for (int r = 0; r < 4; r++) begin
      serve(2, LW'(32'hC0DE_0000 + r), who);
      dut_grants.push_back(who);
    end
    i_pmem_read = 0; d_pmem_read = 0;
    chk("rr_order", LW'({dut_grants[0], dut_grants[1], dut_grants[2], dut_grants[3]}),
        LW'({32'd2, 32'd1, 32'd2, 32'd1}));
    chk("rr_model", LW'({model_grants[0], model_grants[1], model_grants[2], model_grants[3]}),
        LW'({32'd2, 32'd1, 32'd2, 32'd1}));
    chk("rr_d_rdata", d_pmem_rdata, LW'(32'hC0DE_0002));
    chk("rr_i_rdata", i_pmem_rdata, LW'(32'hC0DE_0003));
    tick();
    i_pmem_read = 1; i_pmem_address = 32'h0000_1040;
    tick();
    chk("i_addr", LW'(pmem_address_c), LW'(32'h0000_1040));
    chk("i_read", LW'(pmem_read_c), LW'(1));
    pat = {8{32'h1234_5678}};
    serve(10, pat, who);
    i_pmem_read = 0;
    chk("i_who", LW'(who), LW'(1));
    chk("i_rdata_hold", i_pmem_rdata, pat);
    tick();
    chk("idle_after_i", LW'({pmem_read_c, pmem_write_c}), '0);
    d_pmem_write = 1; d_pmem_address = 32'h0000_3000; d_pmem_wdata = {32{8'hA5}};
    tick();
    d_pmem_wdata = '0;
    chk("w_write_c", LW'(pmem_write_c), LW'(1));
    chk("w_read_c", LW'(pmem_read_c), '0);
    chk("w_wdata", pmem_wdata_c, {32{8'hA5}});
    serve(4, '1, who);
    d_pmem_write = 0;
    chk("w_who", LW'(who), LW'(2));
    tick();
    d_pmem_write = 1; d_pmem_wdata = {32{8'h5A}};
    repeat (2) tick();
    chk("w2_write_c", LW'(pmem_write_c), LW'(1));
    rst = 1;
    #1;
    chk("mid_rst_write", LW'(pmem_write_c), '0);
    chk("mid_rst_addr", LW'(pmem_address_c), '0);
    d_pmem_write = 0;
    tick();
    rst = 0;
    tick();
    chk("post_rst_idle", LW'({pmem_read_c, pmem_write_c}), '0);
    i_pmem_read = 1; i_pmem_address = 32'h0000_5010;
    tick();
    i_pmem_read = 0;
    serve(3, {8{32'hFEED_BEEF}}, who);
    chk("drop_who", LW'(who), LW'(1));
    chk("drop_addr_model", LW'(m_addr), LW'(32'h0000_5000));
    tick();
    d_pmem_read = 1; d_pmem_address = 32'h0000_601F;
    tick();
    chk("dr_addr", LW'(pmem_address_c), LW'(32'h0000_6000));
    serve(1, {4{64'h0123_4567_89AB_CDEF}}, who);
    d_pmem_read = 0;
    chk("dr_who", LW'(who), LW'(2));
    chk("dr_rdata_hold", d_pmem_rdata, {4{64'h0123_4567_89AB_CDEF}});
    repeat (3) tick();
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
